pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Turns the ID-stage hazard flag and the registered EX/MEM branch-taken flag into PC enable, IF/ID enable and per-register flush controls.
- Tracks which stages hold valid instructions through shadow valid bits.
- Runs a halt/drain handshake for debug and test control.
- Keeps stall, flush and retire counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- hazard_detected_i  in  1  ID instruction depends on a pending write in EX, MEM or WB.
- br_taken_i  in  1  EX/MEM branch/jump taken; the PC redirect happens this cycle.
- halt_req_i  in  1  level request to stop fetch and drain the pipeline.
- pc_en_o  out  1  PC register load enable.
- if_id_en_o  out  1  IF/ID register load enable.
- if_id_flush_o  out  1  IF/ID loads a bubble; dominates if_id_en_o.
- id_ex_flush_o  out  1  ID/EX loads a bubble.
- ex_mem_flush_o  out  1  EX/MEM loads a bubble.
- halt_ack_o  out  1  pipeline empty and fetch frozen.
- stall_cnt_o  out  CNT_W  cycles with a stall.
- flush_cnt_o  out  CNT_W  cycles with br_taken_i high.
- retire_cnt_o  out  CNT_W  valid instructions that reached WB.

## Operation
- State: FSM {RUN, DRAIN, HALTED}; shadow valid bits v_id, v_ex, v_mem, v_wb; three counters.
- Internal terms:
  - flush = br_taken_i
  - stall = hazard_detected_i & v_id & ~flush
  - fetch = (state == RUN)
- Outputs (combinational from state and inputs):
  - pc_en_o = flush | (fetch & ~stall)
  - if_id_en_o = ~stall
  - if_id_flush_o = flush | (~fetch & ~stall)
  - id_ex_flush_o = flush | stall
  - ex_mem_flush_o = flush
  - halt_ack_o = (state == HALTED)
- Valid update, first match wins:
  - flush: v_id, v_ex, v_mem <= 0; v_wb <= v_mem.
  - stall: v_id holds; v_ex <= 0; v_mem <= v_ex; v_wb <= v_mem.
  - else: v_id <= fetch; v_ex <= v_id; v_mem <= v_ex; v_wb <= v_mem.
- Hazard handling: a bubble in ID (v_id = 0) never stalls.
- Branch in DRAIN or HALTED: pc_en_o = 1, so the redirect target is captured in the PC, but nothing is fetched as valid. On resume, fetch starts at the correct PC.
- FSM transitions:
  - RUN -> DRAIN when halt_req_i = 1.
  - DRAIN -> RUN when halt_req_i = 0 (drain aborted; PC still points at the first unfetched instruction).
  - DRAIN -> HALTED when halt_req_i = 1, all four valid bits are 0, and flush = 0.
  - HALTED -> RUN when halt_req_i = 0.
- Counters (each wraps modulo 2^CNT_W, no saturation):
  - stall_cnt +1 every cycle stall = 1.
  - flush_cnt +1 every cycle flush = 1.
  - retire_cnt +1 every cycle v_wb = 1.

## Timing
- Reset (reset_n = 0 at an edge):
  - state <= RUN; all valid bits and counters <= 0.
  - Overrides every other event, including mid-drain and simultaneous branch.
  - Output values in the first cycle after reset: pc_en_o = 1, if_id_en_o = 1, all flushes = 0, halt_ack_o = 0, counters = 0.
- Control outputs are zero-latency (same-cycle) functions of the inputs; there is no registered path from hazard or branch to the enables.
- Counters and the FSM update at the edge ending the cycle in which their condition held.
- Branch and hazard in the same cycle: the branch wins; no stall, and stall_cnt does not increment.
- halt_req_i asserted in RUN: the fetch in that same cycle is still valid; DRAIN begins next cycle.
- Full-pipe drain: halt_req_i rises in cycle 0 with no hazards or branches.
  - DRAIN in cycles 1–5; empty detected in cycle 5.
  - halt_ack_o = 1 from cycle 6.
- Stalls during DRAIN extend the drain one cycle per stall cycle.
- halt_req_i must stay high until halt_ack_o is seen; dropping it earlier aborts the drain without error.

## Test plan
- Reset release with no hazards: after 5 cycles v_wb = 1; after 10 more cycles retire_cnt_o = 10, stall_cnt_o = 0, pc_en_o = 1 throughout.
- hazard_detected_i held 2 cycles with v_id = 1 -> in both cycles pc_en_o = 0, if_id_en_o = 0, id_ex_flush_o = 1; stall_cnt_o = 2; the ID instruction retires 2 cycles later than it would without the stall.
- br_taken_i pulse for 1 cycle -> if_id_flush_o, id_ex_flush_o, ex_mem_flush_o and pc_en_o all 1 in that cycle; flush_cnt_o = 1; exactly 3 fewer retirements than a no-branch run over the same window.
- br_taken_i and hazard_detected_i high together -> stall_cnt_o unchanged, flush_cnt_o +1, if_id_flush_o = 1.
- Full pipe, halt_req_i rises in cycle 0 -> halt_ack_o = 1 from cycle 6; retire_cnt_o +4; pc_en_o = 0 in cycles 1–6. Release halt_req_i -> RUN next cycle and pc_en_o = 1.
- reset_n low for 1 cycle during DRAIN with stall_cnt_o = 7 -> next cycle: state RUN, halt_ack_o = 0, all counters 0, pc_en_o = 1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline sequencer with hazard/branch control, valid tracking, halt/drain and perf counters
module pipeline_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             hazard_detected_i,
   input  logic             br_taken_i,
   input  logic             halt_req_i,
   output logic             pc_en_o,
   output logic             if_id_en_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_flush_o,
   output logic             halt_ack_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] retire_cnt_o
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   state_t state_q, state_d;
   logic v_id_q, v_ex_q, v_mem_q, v_wb_q;
   logic v_id_d, v_ex_d, v_mem_d, v_wb_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, retire_cnt_d;
   logic flush, stall, fetch, empty;
   // a taken branch squashes the ID instruction, so it can never stall in the same cycle
   always_comb begin
      flush = br_taken_i;
      stall = hazard_detected_i & v_id_q & ~flush;
      fetch = (state_q == RUN);
      empty = ~(v_id_q | v_ex_q | v_mem_q | v_wb_q);
   end
   // same-cycle enables and flushes; a branch always loads the redirect target into the PC
   always_comb begin
      pc_en_o        = flush | (fetch & ~stall);
      if_id_en_o     = ~stall;
      if_id_flush_o  = flush | (~fetch & ~stall);
      id_ex_flush_o  = flush | stall;
      ex_mem_flush_o = flush;
      halt_ack_o     = (state_q == HALTED);
      stall_cnt_o    = stall_cnt_q;
      flush_cnt_o    = flush_cnt_q;
      retire_cnt_o   = retire_cnt_q;
   end
   // next shadow valids, drain FSM and counters
   always_comb begin
      v_id_d       = flush ? 1'b0 : stall ? v_id_q : fetch;
      v_ex_d       = (flush | stall) ? 1'b0 : v_id_q;
      v_mem_d      = flush ? 1'b0 : v_ex_q;
      v_wb_d       = v_mem_q;
      stall_cnt_d  = stall_cnt_q + CNT_W'(stall);
      flush_cnt_d  = flush_cnt_q + CNT_W'(flush);
      retire_cnt_d = retire_cnt_q + CNT_W'(v_wb_q);
      state_d      = state_q;
      case (state_q)
         RUN:     state_d = halt_req_i ? DRAIN : RUN;
         DRAIN:   state_d = ~halt_req_i ? RUN : (empty & ~flush) ? HALTED : DRAIN;
         HALTED:  state_d = halt_req_i ? HALTED : RUN;
         default: state_d = RUN;
      endcase
   end
   // state register; reset overrides any branch or drain in progress
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= RUN;
         v_id_q       <= 1'b0;
         v_ex_q       <= 1'b0;
         v_mem_q      <= 1'b0;
         v_wb_q       <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         v_id_q       <= v_id_d;
         v_ex_q       <= v_ex_d;
         v_mem_q      <= v_mem_d;
         v_wb_q       <= v_wb_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end
endmodule
